branch_resolve_unit: RTL and testbench

EX-stage counterpart of the per-entry 2-bit branch predictor. Records every prediction issued at fetch in a small in-order queue. When EX resolves a branch, it compares the actual outcome with the oldest recorded prediction and drives the predictor's training port (`fb_valid`, `feedback`, `fb_index`). On a mispredict it raises a pipeline flush with the corrected PC.

---
 rtl/bp_pkg.sv | 13 +
 rtl/branch_resolve_unit_if.sv | 32 +++
 rtl/pred_fifo.sv | 56 +++++
 rtl/branch_resolve_unit.sv | 79 +++++++
 tb/tb_branch_resolve_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: the predictor and the EX-side resolve unit
// agree on index/address widths and on the in-flight prediction record.
package bp_pkg;
  localparam int IDX_W  = 8;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fallthru;
  } pred_entry_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-push, EX-resolve and predictor-training/flush signals of the resolve unit.
interface branch_resolve_unit_if #(
    parameter int IDX_W  = bp_pkg::IDX_W,
    parameter int ADDR_W = bp_pkg::ADDR_W
);
    logic              f_push_valid;
    logic              f_push_ready;
    logic [IDX_W-1:0]  f_push_index;
    logic              f_push_taken;
    logic [ADDR_W-1:0] f_push_target;
    logic [ADDR_W-1:0] f_push_fallthru;
    logic              x_br_valid;
    logic              x_br_taken;
    logic [ADDR_W-1:0] x_br_target;
    logic              fb_valid;
    logic              feedback;
    logic [IDX_W-1:0]  fb_index;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output f_push_valid, f_push_index, f_push_taken, f_push_target, f_push_fallthru,
        output x_br_valid, x_br_taken, x_br_target,
        input  f_push_ready, fb_valid, feedback, fb_index, flush, redirect_pc
    );

    modport slave (
        input  f_push_valid, f_push_index, f_push_taken, f_push_target, f_push_fallthru,
        input  x_br_valid, x_br_taken, x_br_target,
        output f_push_ready, fb_valid, feedback, fb_index, flush, redirect_pc
    );
endinterface

// File: rtl/pred_fifo.sv
// In-order circular buffer of prediction records. Clear wins over push/pop;
// full/empty come from the occupancy counter, pointers wrap modulo DEPTH.
module pred_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = pred_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             clear,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push_en, pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full && !clear;
    assign pop_en  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: matches each resolved branch against the oldest
// recorded prediction, trains the predictor and raises a flush on mispredict.
module branch_resolve_unit #(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = bp_pkg::IDX_W,
    parameter int ADDR_W = bp_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_resolve_unit_if.slave     bus,
    input  logic                     ext_flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_underflow
);
    import bp_pkg::*;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [ADDR_W-1:0] fallthru;
    } entry_t;

    entry_t push_data, head;
    logic   full, empty;
    logic   resolve, mispred, clear;

    assign push_data = '{index:    bus.f_push_index,
                         taken:    bus.f_push_taken,
                         target:   bus.f_push_target,
                         fallthru: bus.f_push_fallthru};

    assign bus.f_push_ready = !full;

    // External squash outranks a same-cycle resolve: that branch is gone.
    assign resolve = bus.x_br_valid && !empty && !ext_flush;
    assign mispred = resolve &&
                     ((head.taken != bus.x_br_taken) ||
                      (bus.x_br_taken && (head.target != bus.x_br_target)));
    assign clear   = ext_flush || mispred;

    pred_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.f_push_valid && bus.f_push_ready),
        .push_data (push_data),
        .pop       (resolve),
        .clear     (clear),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fb_valid    <= 1'b0;
            bus.feedback    <= 1'b0;
            bus.fb_index    <= '0;
            bus.flush       <= 1'b0;
            bus.redirect_pc <= '0;
            err_underflow   <= 1'b0;
        end else begin
            bus.fb_valid <= resolve;
            bus.flush    <= mispred;
            if (resolve) begin
                bus.feedback <= bus.x_br_taken;
                bus.fb_index <= head.index;
            end
            if (mispred)
                bus.redirect_pc <= bus.x_br_taken ? bus.x_br_target : head.fallthru;
            if (bus.x_br_valid && empty)
                err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue model of in-flight
// predictions produces expected training/flush results checked one cycle later.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0]  idx;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] ft;
    } mentry_t;

    typedef struct {
        logic [7:0]  idx;
        logic        fb;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ext_flush;
    logic [2:0] count;
    logic       err_underflow;

    branch_resolve_unit_if bus ();

    branch_resolve_unit #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .ext_flush     (ext_flush),
        .count         (count),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int      n_cmp = 0;
    int      n_bad = 0;
    mentry_t mq[$];
    exp_t    exp_q[$];
    logic    m_uf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.f_push_valid = 1'b0; bus.f_push_index = '0; bus.f_push_taken = 1'b0;
        bus.f_push_target = '0; bus.f_push_fallthru = '0;
        bus.x_br_valid = 1'b0; bus.x_br_taken = 1'b0; bus.x_br_target = '0;
        ext_flush = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model, then check at the negedge.
    task automatic cyc(input bit pv, input logic [7:0] idx, input bit tk,
                       input logic [31:0] tgt, input logic [31:0] ft,
                       input bit bv, input bit btk, input logic [31:0] btgt,
                       input bit ef);
        bit      res, mis, push_ok;
        mentry_t h;
        chk("push_ready", bus.f_push_ready, mq.size() < DEPTH);
        bus.f_push_valid = pv; bus.f_push_index = idx; bus.f_push_taken = tk;
        bus.f_push_target = tgt; bus.f_push_fallthru = ft;
        bus.x_br_valid = bv; bus.x_br_taken = btk; bus.x_br_target = btgt;
        ext_flush = ef;

        res = bv && mq.size() > 0 && !ef;
        mis = 1'b0;
        if (bv && mq.size() == 0) m_uf = 1'b1;
        if (res) begin
            h   = mq[0];
            mis = (h.tk != btk) || (btk && h.tgt != btgt);
            exp_q.push_back('{idx: h.idx, fb: btk, fl: mis, pc: btk ? btgt : h.ft});
        end
        push_ok = pv && mq.size() < DEPTH;
        if (ef || mis) mq.delete();
        else begin
            if (res) void'(mq.pop_front());
            if (push_ok) mq.push_back('{idx: idx, tk: tk, tgt: tgt, ft: ft});
        end

        @(posedge clk);
        @(negedge clk);
        drive_idle();
        chk("fb_valid", bus.fb_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            exp_t e = exp_q.pop_front();
            chk("feedback", bus.feedback, e.fb);
            chk("fb_index", bus.fb_index, e.idx);
            chk("flush", bus.flush, e.fl);
            if (e.fl) chk("redirect_pc", bus.redirect_pc, e.pc);
        end else begin
            chk("flush_idle", bus.flush, 0);
        end
        chk("count", count, mq.size());
        chk("err_underflow", err_underflow, m_uf);
    endtask

    task automatic push(input logic [7:0] idx, input bit tk, input logic [31:0] tgt,
                        input logic [31:0] ft);
        cyc(1, idx, tk, tgt, ft, 0, 0, 0, 0);
    endtask

    task automatic resolve(input bit btk, input logic [31:0] btgt);
        cyc(0, 0, 0, 0, 0, 1, btk, btgt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("rst_fb_valid", bus.fb_valid, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_count", count, 0);
        chk("rst_redirect", bus.redirect_pc, 0);
        chk("rst_underflow", err_underflow, 0);
        chk("rst_ready", bus.f_push_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct taken prediction.
        push(8'd3, 1, 32'h100, 32'h0FC);
        resolve(1, 32'h100);
        // Direction mispredict.
        push(8'd5, 0, 32'h280, 32'h204);
        resolve(1, 32'h300);
        // Target mispredict, then taken-predicted resolved not-taken.
        push(8'd6, 1, 32'h100, 32'h044);
        resolve(1, 32'h180);
        push(8'd7, 1, 32'h200, 32'h0C4);
        resolve(0, 32'h0);

        // Fill, overflow attempt, mispredict with simultaneous push.
        for (int i = 1; i <= 4; i++) push(8'(i), 0, 32'h400, 32'h500 + 32'(i * 4));
        push(8'd9, 0, 32'h400, 32'h600);
        cyc(1, 8'd10, 0, 0, 32'h700, 1, 1, 32'h800, 0);

        // Wrap: back-to-back push/pop pairs, all correctly predicted not-taken.
        push(8'd20, 0, 32'h0, 32'h1000);
        for (int i = 1; i <= 10; i++)
            cyc(1, 8'(20 + i), 0, 32'h0, 32'h1000 + 32'(i * 4), 1, 0, 32'h0, 0);
        resolve(0, 32'h0);

        // Underflow: sticky, no feedback.
        resolve(1, 32'h40);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // External flush beats a same-cycle resolve and push.
        push(8'd30, 1, 32'h900, 32'h904);
        push(8'd31, 0, 32'h910, 32'h914);
        cyc(1, 8'd32, 0, 0, 32'h920, 1, 0, 32'h0, 1);

        // Reset arriving before the edge that would register the resolve.
        push(8'd40, 1, 32'hA00, 32'hA04);
        bus.x_br_valid = 1'b1; bus.x_br_taken = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        mq.delete(); exp_q.delete(); m_uf = 1'b0;
        chk("rstmid_fb_valid", bus.fb_valid, 0);
        chk("rstmid_feedback", bus.feedback, 0);
        chk("rstmid_fb_index", bus.fb_index, 0);
        chk("rstmid_flush", bus.flush, 0);
        chk("rstmid_redirect", bus.redirect_pc, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_underflow", err_underflow, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
